// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer that walks a register range between the register file and a context memory.
// Latency: save takes N busy cycles and restore takes N+1 busy cycles (one prime cycle); done pulses in the cycle after the last busy cycle.
// Backpressure: busy stalls the pipeline; cpu_* is ignored while busy, and requests are only sampled in IDLE.
module regfile_ctx_seq #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_req,
    input  logic              restore_req,
    output logic              busy,
    output logic              done,
    input  logic              cpu_WE,
    input  logic [4:0]        cpu_rW,
    input  logic [31:0]       cpu_W,
    input  logic [4:0]        cpu_rA,
    output logic              rf_WE,
    output logic [4:0]        rf_rW,
    output logic [31:0]       rf_W,
    output logic [4:0]        rf_rA,
    input  logic [31:0]       rf_A,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, SAVE, RPRIME, RESTORE} state_t;

    localparam logic [4:0]        FIRST = 5'(FIRST_REG);
    localparam logic [4:0]        LAST  = 5'(LAST_REG);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t            state, state_nxt;
    logic [4:0]        idx, idx_nxt;
    logic              done_nxt;
    logic [ADDR_W-1:0] slot_addr;

    // Slot of the current register; wraps silently modulo 2^ADDR_W.
    assign slot_addr = BASE + ADDR_W'(idx - FIRST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= FIRST;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (save_req) begin
                    state_nxt = SAVE;
                    idx_nxt   = FIRST;
                end else if (restore_req) begin
                    state_nxt = RPRIME;
                    idx_nxt   = FIRST;
                end
            end
            SAVE, RESTORE: begin
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx + 5'd1;
                end
            end
            RPRIME:  state_nxt = RESTORE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        rf_WE     = cpu_WE;
        rf_rW     = cpu_rW;
        rf_W      = cpu_W;
        rf_rA     = cpu_rA;
        mem_addr  = BASE;
        mem_we    = 1'b0;
        mem_wdata = rf_A;
        case (state)
            SAVE: begin
                rf_WE    = 1'b0;
                rf_rW    = 5'd0;
                rf_W     = 32'd0;
                rf_rA    = idx;
                mem_addr = slot_addr;
                mem_we   = 1'b1;
            end
            RPRIME: begin
                rf_WE = 1'b0;
                rf_rW = 5'd0;
                rf_W  = 32'd0;
                rf_rA = 5'd0;
            end
            RESTORE: begin
                // Read data for idx was addressed last cycle, so fetch one slot ahead.
                rf_WE    = 1'b1;
                rf_rW    = idx;
                rf_W     = mem_rdata;
                rf_rA    = 5'd0;
                mem_addr = slot_addr + ADDR_W'(1);
            end
            default: ;
        endcase
        if (rst) begin
            rf_WE  = 1'b0;
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// Bench for regfile_ctx_seq: register-file and context-memory models around the DUT, with an array-based reference of expected contents.
module tb_regfile_ctx_seq;

    logic        clk, rst;
    logic        save_req, restore_req, busy, done;
    logic        cpu_WE;
    logic [4:0]  cpu_rW, cpu_rA;
    logic [31:0] cpu_W;
    logic        rf_WE;
    logic [4:0]  rf_rW, rf_rA;
    logic [31:0] rf_W, rf_A;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    logic        save_req2, restore_req2, busy2, done2;
    logic        rf_WE2;
    logic [4:0]  rf_rW2, rf_rA2;
    logic [31:0] rf_W2, rf_A2;
    logic [7:0]  mem_addr2;
    logic        mem_we2;
    logic [31:0] mem_wdata2;

    logic [31:0] rf  [32];
    logic [31:0] mem [256];
    logic        tb_mem_we;
    logic [7:0]  tb_mem_addr;
    logic [31:0] tb_mem_data;

    logic [31:0] ref_rf  [32];
    logic [31:0] ref_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    regfile_ctx_seq u_dut (
        .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
        .busy(busy), .done(done), .cpu_WE(cpu_WE), .cpu_rW(cpu_rW), .cpu_W(cpu_W),
        .cpu_rA(cpu_rA), .rf_WE(rf_WE), .rf_rW(rf_rW), .rf_W(rf_W), .rf_rA(rf_rA),
        .rf_A(rf_A), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    regfile_ctx_seq #(.FIRST_REG(8), .LAST_REG(15), .ADDR_W(8), .BASE_ADDR(8'hFC)) u_dut2 (
        .clk(clk), .rst(rst), .save_req(save_req2), .restore_req(restore_req2),
        .busy(busy2), .done(done2), .cpu_WE(1'b0), .cpu_rW(5'd0), .cpu_W(32'd0),
        .cpu_rA(5'd0), .rf_WE(rf_WE2), .rf_rW(rf_rW2), .rf_W(rf_W2), .rf_rA(rf_rA2),
        .rf_A(rf_A2), .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2),
        .mem_rdata(32'h0000_0077)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational reads, falling-edge write, r0 reads as zero.
    assign rf_A  = (rf_rA == 5'd0) ? 32'd0 : rf[rf_rA];
    assign rf_A2 = 32'h5000 + 32'(rf_rA2);
    always @(negedge clk) if (rf_WE && rf_rW != 5'd0) rf[rf_rW] <= rf_W;

    always @(posedge clk) begin
        if (tb_mem_we)   mem[tb_mem_addr] <= tb_mem_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(input int i, input logic [31:0] v);
        cpu_WE = 1'b1; cpu_rW = 5'(i); cpu_W = v;
        step();
        cpu_WE = 1'b0;
        if (i != 0) ref_rf[i] = v;
    endtask

    task automatic wr_mem(input int a, input logic [31:0] v);
        tb_mem_we = 1'b1; tb_mem_addr = 8'(a); tb_mem_data = v;
        step();
        tb_mem_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Full save of r1..r31 to slots 0..30; optional simultaneous restore and mid-run save pulse.
    task automatic run_save(input bit with_restore, input int bump);
        save_req = 1'b1; restore_req = with_restore;
        step();
        save_req = 1'b0; restore_req = 1'b0;
        cpu_WE = 1'b1; cpu_rW = 5'd3; cpu_W = $urandom;
        for (int c = 1; c <= 31; c++) begin
            chk("save_busy", 32'(busy), 1);
            chk("save_mem_we", 32'(mem_we), 1);
            chk("save_rf_we", 32'(rf_WE), 0);
            chk("save_addr", 32'(mem_addr), 32'(c - 1));
            chk("save_data", mem_wdata, ref_rf[c]);
            save_req = (c == bump);
            if (c == 31) cpu_WE = 1'b0;
            step();
        end
        save_req = 1'b0;
        chk("save_done", 32'(done), 1);
        chk("save_idle", 32'(busy), 0);
        chk("save_we_after", 32'(mem_we), 0);
        for (int k = 0; k < 31; k++) ref_mem[k] = ref_rf[k + 1];
        step();
        chk("save_done_clr", 32'(done), 0);
        chk("save_no_restore", 32'(busy), 0);
        for (int k = 0; k < 31; k++) chk("save_mem_content", mem[k], ref_mem[k]);
    endtask

    task automatic run_restore();
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        cpu_rW = 5'd9; cpu_W = $urandom;
        chk("rprime_busy", 32'(busy), 1);
        chk("rprime_rf_we", 32'(rf_WE), 0);
        chk("rprime_mem_we", 32'(mem_we), 0);
        chk("rprime_addr", 32'(mem_addr), 0);
        step();
        for (int c = 2; c <= 32; c++) begin
            chk("rest_busy", 32'(busy), 1);
            chk("rest_rf_we", 32'(rf_WE), 1);
            chk("rest_rw", 32'(rf_rW), 32'(c - 1));
            chk("rest_w", rf_W, ref_mem[c - 2]);
            chk("rest_mem_we", 32'(mem_we), 0);
            step();
        end
        chk("rest_done", 32'(done), 1);
        chk("rest_idle", 32'(busy), 0);
        for (int k = 0; k < 31; k++) ref_rf[k + 1] = ref_mem[k];
        for (int i = 0; i < 32; i++) begin
            cpu_rA = 5'(i);
            #1;
            chk("rest_readback", rf_A, ref_rf[i]);
        end
        step();
        chk("rest_done_clr", 32'(done), 0);
    endtask

    initial begin
        int seen_done, seen_we;
        rst = 1'b1; save_req = 0; restore_req = 0; save_req2 = 0; restore_req2 = 0;
        cpu_WE = 0; cpu_rW = 0; cpu_W = 0; cpu_rA = 0;
        tb_mem_we = 0; tb_mem_addr = 0; tb_mem_data = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        step(); step();

        cpu_WE = 1'b1;
        #1;
        chk("rst_rf_we", 32'(rf_WE), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0; cpu_WE = 1'b0;
        step();

        cpu_WE = 1'b1; cpu_rW = 5'd5; cpu_W = 32'hDEADBEEF; cpu_rA = 5'd7;
        #1;
        chk("pass_we", 32'(rf_WE), 1);
        chk("pass_rw", 32'(rf_rW), 5);
        chk("pass_w", rf_W, 32'hDEADBEEF);
        chk("pass_ra", 32'(rf_rA), 7);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_mem_we", 32'(mem_we), 0);
        step();
        cpu_WE = 1'b0;
        ref_rf[5] = 32'hDEADBEEF;

        // Fixed-pattern save with both requests and a mid-save save pulse, then fixed restore.
        for (int i = 1; i < 32; i++) wr_reg(i, 32'h100 + 32'(i));
        run_save(1'b1, 5);
        for (int k = 0; k < 31; k++) wr_mem(k, 32'hA000 + 32'(k));
        run_restore();

        // Randomized round trip.
        for (int i = 1; i < 32; i++) wr_reg(i, $urandom);
        run_save(1'b0, 0);
        for (int k = 0; k < 31; k++) wr_mem(k, $urandom);
        run_restore();

        // Reset in cycle 10 of a save: slots 0..8 updated, the rest keep old contents.
        for (int i = 1; i < 32; i++) wr_reg(i, $urandom);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        #1;
        chk("midrst_mem_we", 32'(mem_we), 0);
        step();
        chk("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        cpu_rA = 5'd4; cpu_WE = 1'b0;
        #1;
        chk("midrst_pass_ra", 32'(rf_rA), 4);
        seen_done = 0; seen_we = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen_done++;
            if (mem_we) seen_we++;
            step();
        end
        chk("midrst_no_done", 32'(seen_done), 0);
        chk("midrst_no_writes", 32'(seen_we), 0);
        for (int k = 0; k < 9; k++) ref_mem[k] = ref_rf[k + 1];
        for (int k = 0; k < 31; k++) chk("midrst_mem", mem[k], ref_mem[k]);

        // Narrow range r8..r15 at base 0xFC: slot addresses wrap past 0xFF.
        save_req2 = 1'b1;
        step();
        save_req2 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("r2_save_busy", 32'(busy2), 1);
            chk("r2_save_we", 32'(mem_we2), 1);
            chk("r2_save_addr", 32'(mem_addr2), (32'hFC + 32'(c - 1)) % 256);
            chk("r2_save_data", mem_wdata2, 32'h5000 + 32'(8 + c - 1));
            step();
        end
        chk("r2_save_done", 32'(done2), 1);
        chk("r2_save_idle", 32'(busy2), 0);
        step();
        restore_req2 = 1'b1;
        step();
        restore_req2 = 1'b0;
        chk("r2_rprime_addr", 32'(mem_addr2), 32'hFC);
        chk("r2_rprime_we", 32'(rf_WE2), 0);
        step();
        for (int c = 2; c <= 9; c++) begin
            chk("r2_rest_we", 32'(rf_WE2), 1);
            chk("r2_rest_rw", 32'(rf_rW2), 32'(8 + c - 2));
            chk("r2_rest_w", rf_W2, 32'h77);
            if (c < 9) chk("r2_rest_addr", 32'(mem_addr2), (32'hFC + 32'(c - 1)) % 256);
            step();
        end
        chk("r2_rest_done", 32'(done2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_ctx_seq.md
# regfile_ctx_seq

Context save/restore sequencer for the 32×32 register file (two combinational read ports, one write port committed on the falling clock edge, register 0 hard-wired to zero). On a save request it walks a configurable register range and stores each register into a word-addressed context memory. On a restore request it reloads the range from that memory. While sequencing it owns the register file's rA read port and W write port and stalls the pipeline; when idle it passes the pipeline's requests straight through.

## Interface
Parameters:
- FIRST_REG, 1: first register index in the range (1..31).
- LAST_REG, 31: last register index in the range (≥ FIRST_REG, ≤ 31).
- ADDR_W, 8: context memory word-address width.
- BASE_ADDR, 0: memory word address of FIRST_REG's slot.

Ports (N = LAST_REG − FIRST_REG + 1):
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- save_req  in  1  start save; sampled in IDLE only.
- restore_req  in  1  start restore; sampled in IDLE only.
- busy  out  1  sequence in progress; also the pipeline stall.
- done  out  1  one-cycle pulse after a sequence completes.
- cpu_WE  in  1  pipeline write enable.
- cpu_rW  in  5  pipeline write index.
- cpu_W  in  32  pipeline write data.
- cpu_rA  in  5  pipeline port-A read index.
- rf_WE  out  1  to register file WE.
- rf_rW  out  5  to register file rW.
- rf_W  out  32  to register file W.
- rf_rA  out  5  to register file rA.
- rf_A  in  32  register file port-A data (combinational).
- mem_addr  out  ADDR_W  context memory word address.
- mem_we  out  1  context memory write enable.
- mem_wdata  out  32  context memory write data.
- mem_rdata  in  32  context memory read data, valid one cycle after mem_addr (synchronous read).

## Operation
- States: IDLE, SAVE, RPRIME, RESTORE. A 5-bit index register idx holds the current register number.
- IDLE:
  - rf_WE/rf_rW/rf_W/rf_rA = cpu_* (combinational pass-through).
  - mem_we = 0; busy = 0.
  - save_req → SAVE with idx = FIRST_REG.
  - Otherwise restore_req → RPRIME with idx = FIRST_REG.
  - If both requests are high in the same cycle, save wins and restore_req is dropped.
- SAVE:
  - rf_rA = idx; mem_addr = BASE_ADDR + (idx − FIRST_REG); mem_wdata = rf_A; mem_we = 1; rf_WE = 0.
  - idx increments each cycle. At idx = LAST_REG → IDLE, with done asserted the next cycle.
- RPRIME:
  - mem_addr = BASE_ADDR; rf_WE = 0; mem_we = 0.
  - Next state is RESTORE with idx unchanged.
- RESTORE:
  - rf_WE = 1; rf_rW = idx; rf_W = mem_rdata.
  - mem_addr = BASE_ADDR + (idx − FIRST_REG) + 1. This address is don't-care on the last cycle.
  - idx increments each cycle. At idx = LAST_REG → IDLE, with done asserted the next cycle.
- While busy, the cpu_* inputs are ignored (not queued). rf_rA = idx during SAVE and 0 during RPRIME/RESTORE.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- If FIRST_REG = 0, register 0 is saved as 0. Its restore write is discarded by the register file.
- Requests arriving while busy are ignored. A request in the cycle done is high is accepted normally, because the FSM is already in IDLE.

## Timing
- Reset (rst high at a rising edge):
  - state = IDLE, idx = FIRST_REG, done = 0.
  - While rst is high, rf_WE = 0 and mem_we = 0 are forced regardless of cpu_WE.
  - Reset mid-sequence aborts immediately. Partial memory/register contents are left as written, and no done pulse is produced.
- Save, request sampled at edge 0:
  - busy is high for cycles 1..N; one memory write per cycle.
  - done is high in cycle N+1.
- Restore, request sampled at edge 0:
  - busy is high for cycles 1..N+1. Cycle 1 is RPRIME; cycles 2..N+1 write registers FIRST_REG..LAST_REG.
  - done is high in cycle N+2.
- rf_WE is held for the whole cycle, so the register file's falling-edge commit lands mid-cycle.
- done is a registered output. busy and all rf_*/mem_* outputs are combinational from state and idx.

## Test plan
- Reset then idle: pulse rst; drive cpu_WE=1, cpu_rW=5, cpu_W=0xDEADBEEF → rf_* mirror cpu_*, busy=0, done=0, mem_we=0.
- Full save with defaults: preload r1..r31 = 0x100+i; pulse save_req → 31 consecutive mem writes, addr 0..30, data 0x101..0x11F; busy high 31 cycles; done pulse in cycle 32.
- Full restore: memory word k = 0xA000+k; pulse restore_req → RPRIME cycle, then 31 register writes with r(k+1) = 0xA000+k; done pulse in cycle 33; r0 stays 0.
- Simultaneous requests: save_req and restore_req high together → save sequence only, no restore. save_req pulsed mid-save → ignored; exactly 31 writes occur.
- Reset mid-save at cycle 10 → busy=0 next cycle, no further mem writes, no done pulse, cpu pass-through restored.
- Parameter range FIRST_REG=8, LAST_REG=15, BASE_ADDR=0xFC → save writes addr 0xFC..0xFF then 0x00..0x03 (wrap); done in cycle 9.
